// File: rtl/aesl_deadlock_pkg.sv
// rtl/aesl_deadlock_pkg.sv - shared types and helpers for the AXI-Stream block generator
// Contents:
//   state_t               detector FSM encoding (IDLE / ARMED / FLAGGED)
//   DEFAULT_STALL_THRESH  default consecutive-wait threshold
//   cnt_width()           counter width able to hold 0..thresh
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FLAGGED = 2'd2
  } state_t;

  localparam int DEFAULT_STALL_THRESH = 1024;

  function automatic int cnt_width(input int thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/aesl_deadlock_stall_cnt.sv
// rtl/aesl_deadlock_stall_cnt.sv - per-channel saturating stall counter with threshold compare
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset
//   clear     in   global clear (enable low, any handshake, or all instances idle)
//   waiting   in   this channel has exactly one of valid/ready high
//   block     out  counter sits at STALL_THRESH (registered state decode)
//   hit_next  out  counter will be at STALL_THRESH after this edge
module aesl_deadlock_stall_cnt
  import aesl_deadlock_pkg::*;
#(
  parameter int STALL_THRESH = DEFAULT_STALL_THRESH,
  parameter int CW           = cnt_width(STALL_THRESH)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic block,
  output logic hit_next
);

  localparam logic [CW-1:0] THRESH = CW'(STALL_THRESH);

  logic [CW-1:0] count;
  logic [CW-1:0] cnt_next;

  // Clears win over increment; at the threshold the count holds (never wraps).
  always_comb begin
    cnt_next = count;
    if (clear || !waiting) begin
      cnt_next = '0;
    end else if (count != THRESH) begin
      cnt_next = count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= cnt_next;
    end
  end

  assign block    = (count == THRESH);
  assign hit_next = (cnt_next == THRESH);

endmodule

// File: rtl/aesl_deadlock_axis_block_gen.sv
// rtl/aesl_deadlock_axis_block_gen.sv - flags AXI-Stream channels stalled for STALL_THRESH cycles
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous active-high reset
//   enable           in   detection enable; low clears and holds all state
//   ch_valid         in   per-channel TVALID
//   ch_ready         in   per-channel TREADY
//   inst_idle_sigs   in   per-instance idle flags
//   axis_block_sigs  out  per-channel blocked flags
//   any_block        out  OR of axis_block_sigs
//   first_block_idx  out  first channel flagged in the current blocked episode
//   first_block_vld  out  first_block_idx is valid
module aesl_deadlock_axis_block_gen
  import aesl_deadlock_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int NUM_INST     = 5,
  parameter int STALL_THRESH = DEFAULT_STALL_THRESH,
  parameter int IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic [IDX_W-1:0]  first_block_idx,
  output logic              first_block_vld
);

  logic [NUM_CH-1:0] waiting;
  logic [NUM_CH-1:0] hit_next;
  logic              global_progress;
  logic              all_idle;
  logic              clear;
  logic [IDX_W-1:0]  low_idx;
  state_t            state;

  assign waiting         = ch_valid ^ ch_ready;
  assign global_progress = |(ch_valid & ch_ready);
  assign all_idle        = &inst_idle_sigs;
  assign clear           = !enable || global_progress || all_idle;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aesl_deadlock_stall_cnt #(
      .STALL_THRESH(STALL_THRESH)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear),
      .waiting (waiting[i]),
      .block   (axis_block_sigs[i]),
      .hit_next(hit_next[i])
    );
  end

  assign any_block = |axis_block_sigs;

  // Scan high-to-low so the lowest reaching channel is written last.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit_next[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // FSM tracks counter next-state so first_block_vld rises and falls on the
  // same edge as the block flags it describes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      first_block_vld <= 1'b0;
      first_block_idx <= '0;
    end else if (!enable) begin
      state           <= ST_IDLE;
      first_block_vld <= 1'b0;
    end else begin
      case (state)
        // A threshold of 1 can be reached on the very first enabled edge,
        // so IDLE also honours a hit instead of losing the episode start.
        ST_IDLE, ST_ARMED: begin
          if (|hit_next) begin
            state           <= ST_FLAGGED;
            first_block_idx <= low_idx;
            first_block_vld <= 1'b1;
          end else begin
            state <= ST_ARMED;
          end
        end
        ST_FLAGGED: begin
          if (!(|hit_next)) begin
            state           <= ST_ARMED;
            first_block_vld <= 1'b0;
          end
        end
        default: begin
          state           <= ST_IDLE;
          first_block_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aesl_deadlock_axis_block_gen.sv
// tb/tb_aesl_deadlock_axis_block_gen.sv - directed self-checking bench for aesl_deadlock_axis_block_gen
module tb_aesl_deadlock_axis_block_gen;

  localparam int NUM_CH   = 8;
  localparam int NUM_INST = 5;
  localparam int THRESH   = 8;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [7:0]    ch_valid;
  logic [7:0]    ch_ready;
  logic [4:0]    inst_idle_sigs;
  logic [7:0]    axis_block_sigs;
  logic          any_block;
  logic [2:0]    first_block_idx;
  logic          first_block_vld;

  int total;
  int bad;

  aesl_deadlock_axis_block_gen #(
    .NUM_CH      (NUM_CH),
    .NUM_INST    (NUM_INST),
    .STALL_THRESH(THRESH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .ch_valid       (ch_valid),
    .ch_ready       (ch_ready),
    .inst_idle_sigs (inst_idle_sigs),
    .axis_block_sigs(axis_block_sigs),
    .any_block      (any_block),
    .first_block_idx(first_block_idx),
    .first_block_vld(first_block_vld)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; outputs are then sampled 1 time unit after the edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic release_all();
    ch_valid = 8'h00;
    ch_ready = 8'h00;
    step(1);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    enable         = 1'b0;
    ch_valid       = 8'h00;
    ch_ready       = 8'h00;
    inst_idle_sigs = 5'h00;
    step(2);
    check("rst_block", axis_block_sigs, 8'h00);
    check("rst_any",   any_block,       1'b0);
    check("rst_vld",   first_block_vld, 1'b0);
    check("rst_idx",   first_block_idx, 3'd0);
    reset = 1'b0;

    // Single channel 3 stalled with valid high, ready low.
    enable   = 1'b1;
    ch_valid = 8'h08;
    step(7);
    check("ch3_pre_block", axis_block_sigs, 8'h00);
    check("ch3_pre_vld",   first_block_vld, 1'b0);
    step(1);
    check("ch3_block", axis_block_sigs, 8'h08);
    check("ch3_any",   any_block,       1'b1);
    check("ch3_idx",   first_block_idx, 3'd3);
    check("ch3_vld",   first_block_vld, 1'b1);
    release_all();
    check("ch3_rel_block", axis_block_sigs, 8'h00);
    check("ch3_rel_vld",   first_block_vld, 1'b0);
    check("ch3_rel_idx",   first_block_idx, 3'd3);

    // Channel 2 interrupted at 7 by a handshake on channel 5.
    ch_valid = 8'h04;
    step(7);
    ch_valid = 8'h24;
    ch_ready = 8'h20;
    step(1);
    check("ch2_prog_block", axis_block_sigs, 8'h00);
    ch_valid = 8'h04;
    ch_ready = 8'h00;
    step(7);
    check("ch2_restart_pre", axis_block_sigs, 8'h00);
    step(1);
    check("ch2_restart_block", axis_block_sigs, 8'h04);
    check("ch2_idx",           first_block_idx, 3'd2);
    release_all();

    // Channels 6 and 1 together; 1 uses ready-only waiting.
    ch_valid = 8'h40;
    ch_ready = 8'h02;
    step(8);
    check("dual_block", axis_block_sigs, 8'h42);
    check("dual_idx",   first_block_idx, 3'd1);
    ch_ready = 8'h00;
    step(1);
    check("dual_rel_block", axis_block_sigs, 8'h40);
    check("dual_rel_idx",   first_block_idx, 3'd1);
    check("dual_rel_vld",   first_block_vld, 1'b1);
    release_all();

    // Channel 0 flagged, then all instances idle for one cycle.
    ch_valid = 8'h01;
    step(8);
    check("idle_pre_block", axis_block_sigs, 8'h01);
    inst_idle_sigs = 5'h1F;
    step(1);
    check("idle_block", axis_block_sigs, 8'h00);
    check("idle_any",   any_block,       1'b0);
    check("idle_vld",   first_block_vld, 1'b0);
    inst_idle_sigs = 5'h00;
    step(7);
    check("idle_recount_pre", axis_block_sigs, 8'h00);
    step(1);
    check("idle_reflag_block", axis_block_sigs, 8'h01);
    check("idle_reflag_vld",   first_block_vld, 1'b1);
    release_all();

    // Channel 4 flagged, reset pulse, waiting continues.
    ch_valid = 8'h10;
    step(8);
    check("rst4_pre_block", axis_block_sigs, 8'h10);
    check("rst4_pre_idx",   first_block_idx, 3'd4);
    reset = 1'b1;
    step(1);
    check("rst4_block", axis_block_sigs, 8'h00);
    check("rst4_any",   any_block,       1'b0);
    check("rst4_vld",   first_block_vld, 1'b0);
    check("rst4_idx",   first_block_idx, 3'd0);
    reset = 1'b0;
    step(7);
    check("rst4_recount_pre", axis_block_sigs, 8'h00);
    step(1);
    check("rst4_reflag_block", axis_block_sigs, 8'h10);
    check("rst4_reflag_idx",   first_block_idx, 3'd4);
    release_all();

    // Channel 7 waits 100 cycles: flag must stay high once reached.
    ch_valid = 8'h80;
    for (int c = 1; c <= 100; c++) begin
      step(1);
      check($sformatf("sat_c%0d", c), axis_block_sigs, (c >= THRESH) ? 8'h80 : 8'h00);
    end

    // Enable falling while flagged.
    enable = 1'b0;
    step(1);
    check("en_off_block", axis_block_sigs, 8'h00);
    check("en_off_vld",   first_block_vld, 1'b0);
    step(3);
    check("en_off_hold",  axis_block_sigs, 8'h00);
    enable = 1'b1;
    step(7);
    check("en_on_pre", axis_block_sigs, 8'h00);
    step(1);
    check("en_on_block", axis_block_sigs, 8'h80);
    check("en_on_idx",   first_block_idx, 3'd7);
    check("en_on_vld",   first_block_vld, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
